// File: rtl/sand_brush.sv
// sand_brush: expands one latched brush command (centre x/y, radius, particle
// type) into single-cell framebuffer writes. The engine walks a (2r+1)x(2r+1)
// window row by row, drops positions that fall off screen, and presents each
// surviving cell on a registered valid/ready write port.
//
// Build option: define SAND_BRUSH_DISK_EN to mask the window to a disk
// (dx^2 + dy^2 <= r^2 + r). Without it the full square is stamped. The scan
// always visits every window position, so cycle counts match in both builds.
module sand_brush #(
    parameter int WIDTH  = 32'd640,
    parameter int HEIGHT = 32'd480,
    parameter int ADDR_W = 32'd19
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [10:0]       write_x,
    input  logic [9:0]        write_y,
    input  logic [1:0]        write_radius,
    input  logic [1:0]        write_t,
    output logic              busy,
    output logic              done,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [1:0]        mem_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_r;
    logic [10:0] x_r;
    logic [9:0]  y_r;
    logic [1:0]  rad_r;
    logic [1:0]  t_r;
    // Window offsets in 3-bit two's complement (range -3..+3).
    logic [2:0]  dx_r;
    logic [2:0]  dy_r;

    // Position about to be presented: either the first one of a new command
    // (taken straight from the command inputs) or the successor in the scan.
    logic [10:0]       src_x_s;
    logic [9:0]        src_y_s;
    logic [1:0]        src_rad_s;
    logic [1:0]        src_t_s;
    logic [2:0]        nxt_dx_s;
    logic [2:0]        nxt_dy_s;
    logic              last_s;
    logic [15:0]       px_s;
    logic [15:0]       py_s;
    logic              in_x_s;
    logic              in_y_s;
    logic              mask_s;
    logic              pos_ok_s;
    logic [ADDR_W-1:0] addr_s;

`ifdef SAND_BRUSH_DISK_EN
    // Disk membership test on the window offsets.
    function automatic logic disk_pass(input logic [2:0] dx, input logic [2:0] dy,
                                       input logic [1:0] r);
        logic [2:0] ax;
        logic [2:0] ay;
        logic [4:0] sum;
        logic [4:0] lim;
        ax  = dx[2] ? (3'd0 - dx) : dx;
        ay  = dy[2] ? (3'd0 - dy) : dy;
        sum = ({2'd0, ax} * {2'd0, ax}) + ({2'd0, ay} * {2'd0, ay});
        lim = ({3'd0, r} * {3'd0, r}) + {3'd0, r};
        return (sum <= lim);
    endfunction
`endif

    // Select the source command and the next window offset in scan order.
    always_comb begin
        src_x_s   = x_r;
        src_y_s   = y_r;
        src_rad_s = rad_r;
        src_t_s   = t_r;
        nxt_dx_s  = dx_r;
        nxt_dy_s  = dy_r;
        last_s    = (dx_r == {1'b0, rad_r}) && (dy_r == {1'b0, rad_r});
        if (state_r == IDLE) begin
            src_x_s   = write_x;
            src_y_s   = write_y;
            src_rad_s = write_radius;
            src_t_s   = write_t;
            nxt_dx_s  = 3'd0 - {1'b0, write_radius};
            nxt_dy_s  = 3'd0 - {1'b0, write_radius};
        end else if (dx_r == {1'b0, rad_r}) begin
            nxt_dx_s = 3'd0 - {1'b0, rad_r};
            nxt_dy_s = dy_r + 3'd1;
        end else begin
            nxt_dx_s = dx_r + 3'd1;
            nxt_dy_s = dy_r;
        end
    end

    // Screen-space position, clipping, masking and cell address of the next position.
    always_comb begin
        px_s   = {5'd0, src_x_s} + {{13{nxt_dx_s[2]}}, nxt_dx_s};
        py_s   = {6'd0, src_y_s} + {{13{nxt_dy_s[2]}}, nxt_dy_s};
        in_x_s = (px_s[15] == 1'b0) && (px_s < 16'(WIDTH));
        in_y_s = (py_s[15] == 1'b0) && (py_s < 16'(HEIGHT));
`ifdef SAND_BRUSH_DISK_EN
        mask_s = disk_pass(nxt_dx_s, nxt_dy_s, src_rad_s);
`else
        mask_s = 1'b1;
`endif
        pos_ok_s = in_x_s && in_y_s && mask_s;
        addr_s   = (ADDR_W'(py_s) * ADDR_W'(WIDTH)) + ADDR_W'(px_s);
    end

    // Command FSM with registered status and write-port outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= IDLE;
            x_r       <= 11'd0;
            y_r       <= 10'd0;
            rad_r     <= 2'd0;
            t_r       <= 2'd0;
            dx_r      <= 3'd0;
            dy_r      <= 3'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_valid <= 1'b0;
            mem_addr  <= '0;
            mem_data  <= 2'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state_r   <= SCAN;
                        x_r       <= write_x;
                        y_r       <= write_y;
                        rad_r     <= write_radius;
                        t_r       <= write_t;
                        dx_r      <= nxt_dx_s;
                        dy_r      <= nxt_dy_s;
                        busy      <= 1'b1;
                        mem_valid <= pos_ok_s;
                        if (pos_ok_s) begin
                            mem_addr <= addr_s;
                            mem_data <= src_t_s;
                        end
                    end
                end
                SCAN: begin
                    // A presented write stays put until the arbiter takes it.
                    if (mem_valid && !mem_ready) begin
                        state_r <= SCAN;
                    end else if (last_s) begin
                        state_r   <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        mem_valid <= 1'b0;
                    end else begin
                        dx_r      <= nxt_dx_s;
                        dy_r      <= nxt_dy_s;
                        mem_valid <= pos_ok_s;
                        if (pos_ok_s) begin
                            mem_addr <= addr_s;
                            mem_data <= src_t_s;
                        end
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    done    <= 1'b0;
                end
                default: begin
                    state_r   <= IDLE;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    mem_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sand_brush.sv
// Bench for sand_brush: an index-based reference model predicts the outputs on
// every cycle; directed commands add literal checks on write sets and timing.
module tb_sand_brush;

    localparam int W = 640;
    localparam int H = 480;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        start = 1'b0;
    logic [10:0] write_x = '0;
    logic [9:0]  write_y = '0;
    logic [1:0]  write_radius = '0;
    logic [1:0]  write_t = '0;
    logic        busy;
    logic        done;
    logic        mem_valid;
    logic        mem_ready = 1'b1;
    logic [18:0] mem_addr;
    logic [1:0]  mem_data;

    int n_checks = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    int wr_a[$];
    int wr_d[$];

    sand_brush dut (
        .clock(clock), .reset_n(reset_n), .start(start),
        .write_x(write_x), .write_y(write_y), .write_radius(write_radius),
        .write_t(write_t), .busy(busy), .done(done), .mem_valid(mem_valid),
        .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: position k of the window, row-major from the top-left corner.
    function automatic bit pos_valid(input int cx, input int cy, input int r,
                                     input int k, output int addr);
        int side, dx, dy, px, py;
        bit ok;
        side = 2 * r + 1;
        dx = (k % side) - r;
        dy = (k / side) - r;
        px = cx + dx;
        py = cy + dy;
        ok = (px >= 0) && (px < W) && (py >= 0) && (py < H);
`ifdef SAND_BRUSH_DISK_EN
        if (dx * dx + dy * dy > r * r + r) ok = 1'b0;
`endif
        addr = py * W + px;
        return ok;
    endfunction

    // Model state and predicted outputs.
    int m_phase = 0;  // 0 idle, 1 scanning, 2 done
    int m_k = 0, m_x = 0, m_y = 0, m_r = 0, m_t = 0;
    bit e_busy = 0, e_done = 0, e_valid = 0;
    int e_addr = 0, e_data = 0;

    always @(posedge clock or negedge reset_n) begin
        int a;
        if (!reset_n) begin
            m_phase = 0; e_busy = 0; e_done = 0; e_valid = 0; e_addr = 0; e_data = 0;
        end else begin
            e_done = 0;
            if (m_phase == 0) begin
                if (start) begin
                    m_x = write_x; m_y = write_y; m_r = write_radius; m_t = write_t;
                    m_k = 0; m_phase = 1; e_busy = 1;
                    e_valid = pos_valid(m_x, m_y, m_r, 0, a);
                    e_addr = a; e_data = m_t;
                end
            end else if (m_phase == 1) begin
                if (!(e_valid && !mem_ready)) begin
                    m_k++;
                    if (m_k == (2 * m_r + 1) * (2 * m_r + 1)) begin
                        m_phase = 2; e_busy = 0; e_done = 1; e_valid = 0;
                    end else begin
                        e_valid = pos_valid(m_x, m_y, m_r, m_k, a);
                        e_addr = a; e_data = m_t;
                    end
                end
            end else begin
                m_phase = 0;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clock) begin
        if (chk_en) begin
            check("busy", busy, e_busy);
            check("done", done, e_done);
            check("mem_valid", mem_valid, e_valid);
            if (e_valid) begin
                check("mem_addr", mem_addr, e_addr);
                check("mem_data", mem_data, e_data);
            end
        end
    end

    // Log accepted writes.
    always @(posedge clock) begin
        if (reset_n && mem_valid && mem_ready) begin
            wr_a.push_back(int'(mem_addr));
            wr_d.push_back(int'(mem_data));
        end
    end

    task automatic issue(input int x, input int y, input int r, input int t);
        @(negedge clock);
        wr_a.delete();
        wr_d.delete();
        write_x = 11'(x); write_y = 10'(y); write_radius = 2'(r); write_t = 2'(t);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    // Starts at cycle index c0 after the start cycle; bounded by limit.
    task automatic wait_done(input int c0, input int limit, output int done_cyc,
                             output int busy_cnt, output int valid_cnt);
        int c;
        c = c0; done_cyc = -1; busy_cnt = 0; valid_cnt = 0;
        while (c <= limit) begin
            if (busy) busy_cnt++;
            if (mem_valid) valid_cnt++;
            if (done) begin
                done_cyc = c;
                break;
            end
            @(negedge clock);
            c++;
        end
        if (done_cyc < 0) check("done_timeout", 0, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_valid"}, mem_valid, 0);
        check({tag, "_addr"}, mem_addr, 0);
        check({tag, "_data"}, mem_data, 0);
    endtask

    initial begin
        int dc, bc, vc, exp_n, first;
        #2 reset_n = 1'b0;
        repeat (3) @(negedge clock);
        check_reset_outputs("reset");
        chk_en = 1'b1;
        reset_n = 1'b1;

        // Centre stamp.
        mem_ready = 1'b1;
        issue(320, 240, 2, 1);
        wait_done(1, 40, dc, bc, vc);
`ifdef SAND_BRUSH_DISK_EN
        exp_n = 21;
        first = 238 * 640 + 319;  // corner (-2,-2) is outside the disk
`else
        exp_n = 25;
        first = 152638;
`endif
        check("centre_done_cycle", dc, 26);
        check("centre_busy_cycles", bc, 25);
        check("centre_valid_cycles", vc, exp_n);
        check("centre_writes", wr_a.size(), exp_n);
        if (wr_a.size() > 0) check("centre_first_addr", wr_a[0], first);
        foreach (wr_d[i]) check("centre_data", wr_d[i], 1);

        // Corner clip.
        issue(0, 0, 1, 3);
        wait_done(1, 20, dc, bc, vc);
        check("corner_done_cycle", dc, 10);
        check("corner_writes", wr_a.size(), 4);
        if (wr_a.size() == 4) begin
            check("corner_a0", wr_a[0], 0);
            check("corner_a1", wr_a[1], 1);
            check("corner_a2", wr_a[2], 640);
            check("corner_a3", wr_a[3], 641);
            check("corner_d", wr_d[3], 3);
        end

        // Backpressure: ready low for 4 cycles.
        mem_ready = 1'b0;
        issue(10, 10, 0, 2);
        for (int c = 1; c <= 5; c++) begin
            check("bp_valid_held", mem_valid, 1);
            check("bp_addr_held", mem_addr, 6410);
            if (c == 5) mem_ready = 1'b1;
            @(negedge clock);
        end
        check("bp_done", done, 1);
        check("bp_valid_after", mem_valid, 0);
        check("bp_writes", wr_a.size(), 1);

        // Start during SCAN is dropped.
        issue(50, 60, 1, 2);
        @(negedge clock);
        write_x = 11'd200;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_done(3, 20, dc, bc, vc);
        check("drop_done_cycle", dc, 10);
        check("drop_writes", wr_a.size(), 9);
        if (wr_a.size() == 9) begin
            check("drop_a0", wr_a[0], 37809);
            check("drop_a4", wr_a[4], 38450);
            check("drop_a8", wr_a[8], 39091);
        end
        @(negedge clock);
        check("drop_idle_busy", busy, 0);

        // Off-screen centre.
        issue(700, 5, 3, 1);
        wait_done(1, 60, dc, bc, vc);
        check("off_done_cycle", dc, 50);
        check("off_valid_cycles", vc, 0);
        check("off_writes", wr_a.size(), 0);

        // Reset while the fifth write is stalled.
        mem_ready = 1'b1;
        issue(100, 100, 3, 2);
        for (int c = 0; c < 60; c++) begin
            if (mem_valid && wr_a.size() == 4) break;
            @(negedge clock);
        end
        check("rst_reached_5th", wr_a.size(), 4);
        mem_ready = 1'b0;
        @(negedge clock);
        check("rst_valid_before", mem_valid, 1);
        #2 reset_n = 1'b0;
        #1 check_reset_outputs("rst_async");
        @(negedge clock);
        check_reset_outputs("rst_next");
        check("rst_no_handshake", wr_a.size(), 4);
        reset_n = 1'b1;
        mem_ready = 1'b1;
        issue(5, 5, 1, 1);
        wait_done(1, 20, dc, bc, vc);
        check("post_rst_done_cycle", dc, 10);
        check("post_rst_writes", wr_a.size(), 9);
        if (wr_a.size() == 9) begin
            check("post_rst_a0", wr_a[0], 2564);
            check("post_rst_a8", wr_a[8], 3846);
        end
        repeat (2) @(negedge clock);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sand_brush.md
# sand_brush

Brush-stamp engine sitting directly downstream of the HPS write-register block: it consumes the latched brush command (cell x, cell y, radius, particle type) and expands it into a sequence of single-cell writes into the sand framebuffer. Each accepted command walks a (2r+1)×(2r+1) window centred on (x, y), clips against the screen edges, optionally masks to a disk, and emits one 2-bit cell write per surviving position over a valid/ready port. The framebuffer arbiter consumes these writes.

## Interface
- WIDTH, 640, screen width in cells
- HEIGHT, 480, screen height in cells
- ADDR_W, 19, framebuffer cell-address width (must satisfy 2^ADDR_W ≥ WIDTH×HEIGHT)

- clock  in  1  single clock; all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle command strobe
- write_x  in  11  brush centre column
- write_y  in  10  brush centre row
- write_radius  in  2  brush radius r, 0..3
- write_t  in  2  particle type written to every stamped cell
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse when a command completes
- mem_valid  out  1  cell write request
- mem_ready  in  1  arbiter accepts write when mem_valid && mem_ready
- mem_addr  out  ADDR_W  cell address = y×WIDTH + x
- mem_data  out  2  particle type

## Operation
- States: IDLE, SCAN, DONE.
- IDLE: start=1 latches x, y, r, t; dx←−r, dy←−r; go to SCAN. start in SCAN/DONE is ignored (command dropped, no effect on latched values).
- SCAN: position (px, py) = (x+dx, y+dy), signed arithmetic at ≥12 bits, no wrap.
  - Position valid iff 0 ≤ px < WIDTH, 0 ≤ py < HEIGHT, and mask passes (see Configuration).
  - Valid: mem_valid=1, mem_addr=py×WIDTH+px, mem_data=t; hold all three stable until mem_ready; advance on the handshake cycle.
  - Invalid: mem_valid=0, advance after one cycle.
  - Advance order: dx increments −r..r; at dx=r, dx←−r and dy increments. Advancing from (dx,dy)=(r,r) goes to DONE.
- DONE: done=1 for one cycle, busy=0, go to IDLE. start in DONE is ignored.
- Centre outside screen (e.g. write_x ≥ WIDTH): every position clipped; command completes with zero writes.
- r=0: exactly one position.
- reset_n low at any time: immediately IDLE, every output 0; an in-flight mem_valid is withdrawn without handshake.

## Timing
- Reset values: busy=0, done=0, mem_valid=0, mem_addr=0, mem_data=0.
- start sampled in cycle N → busy=1 and first position presented in N+1.
- mem_valid, mem_addr, mem_data are registered outputs; no combinational path from mem_ready to any output.
- With mem_ready tied high, a command takes exactly (2r+1)² SCAN cycles, plus one DONE cycle, regardless of clipping.
- Each mem_ready low cycle while mem_valid=1 adds exactly one cycle.
- Earliest next accepted start: the cycle after DONE (IDLE).

## Configuration
- SAND_BRUSH_DISK_EN defined: mask passes iff dx²+dy² ≤ r²+r. Unclipped write counts per r: 0→1, 1→9, 2→21, 3→37.
- Undefined: mask always passes (full square); counts 1, 9, 25, 49.
- Cycle count in SCAN is identical in both builds; masked positions behave as invalid.

## Test plan
- Reset mid-command: r=3 at (100,100), assert reset_n low at 5th write with mem_ready=0 → all outputs 0 next cycle; after release, start is accepted normally.
- Centre stamp: x=320, y=240, r=2, t=1, mem_ready=1 → 21 writes (disk) / 25 (square), first address 238×640+318=152638, done in cycle 26 after start, busy high cycles 1–25.
- Corner clip: x=0, y=0, r=1, t=3 → only addresses 0, 1, 640, 641 written; done after 9 SCAN cycles.
- Backpressure: x=10, y=10, r=0, mem_ready low 4 cycles → mem_valid held 5 cycles with addr 6410 stable; single write; done one cycle after handshake.
- Busy drop: start pulsed again during SCAN with different x → ignored; write set matches first command only.
- Off-screen: x=700, y=5, r=3 → zero mem_valid cycles, done after 49 SCAN cycles.
